// File: rtl/pampy_stack_engine_pkg.sv
// Shared definitions for the pampy stack engine: op-codes, FSM encoding
// and the sizing helpers used by the engine and its spill RAM.
package pampy_stack_engine_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_DUP      = 3'd3,
        OP_SWAP     = 3'd4,
        OP_OVER     = 3'd5,
        OP_REPLACE2 = 3'd6,
        OP_CLEAR    = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int spill_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/pampy_stack_engine_if.sv
// Operation request handshake between a requester and the stack engine.
interface pampy_stack_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op_code;
    logic [DATA_WIDTH-1:0] push_data;

    modport master (
        output op_valid,
        output op_code,
        output push_data,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  push_data,
        output op_ready
    );
endinterface

// File: rtl/pampy_spill_ram.sv
// Single-port spill RAM with synchronous read; holds stack entries below NOS.
module pampy_spill_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 14,
    localparam int AW        = pampy_stack_engine_pkg::spill_aw(WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [0:WORDS-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage write and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= wdata;
        end else if (en) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/pampy_stack_engine.sv
// Hardware stack with TOS/NOS held in registers and deeper entries spilled
// to a synchronous RAM; pops from depth >= 3 take one refill cycle.
module pampy_stack_engine
    import pampy_stack_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CNT_WIDTH = cnt_width(DEPTH)
) (
    input  logic                  general_clk,
    input  logic                  general_reset,
    pampy_stack_engine_if.slave   op,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] top_out,
    output logic [DATA_WIDTH-1:0] next_out,
    output logic [CNT_WIDTH-1:0]  depth_out,
    output logic                  empty,
    output logic                  full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int SPILL_WORDS = DEPTH - 2;
    localparam int SPILL_AW    = spill_aw(SPILL_WORDS);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    state_e                state_r, state_nxt;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] top_r, nos_r, top_nxt, nos_nxt, push_val;
    logic [CNT_WIDTH-1:0]  depth_r, depth_nxt;
    logic                  empty_r, full_r, ovf_r, udf_r;
    logic                  ovf_set, udf_set;
    logic                  push_req, pop_req, push_go;
    logic                  refill_go, accept;
    logic                  ram_en, ram_we;
    logic [SPILL_AW-1:0]   ram_addr, spill_wr_addr, spill_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    op_e                   opc;

    assign accept        = op.op_valid && ready_r;
    assign opc           = op_e'(op.op_code);
    // RAM holds entries 3..depth; the newest spilled word sits at depth-3.
    assign spill_wr_addr = SPILL_AW'(depth_r - CNT_WIDTH'(2));
    assign spill_rd_addr = SPILL_AW'(depth_r - CNT_WIDTH'(3));
    assign push_go       = push_req && !full_r;

    // FSM state register and ready flag.
    always_ff @(posedge general_clk) begin
        if (general_reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt;
            ready_r <= (state_nxt == ST_IDLE);
        end
    end

    // FSM next-state: REFILL lasts exactly one cycle.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (refill_go) begin
                    state_nxt = ST_REFILL;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REFILL: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Operation decode and next-value computation for TOS, NOS and depth.
    always_comb begin
        top_nxt   = top_r;
        nos_nxt   = nos_r;
        depth_nxt = depth_r;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        push_val  = op.push_data;
        if (state_r == ST_REFILL) begin
            nos_nxt = ram_rdata;
        end else if (accept) begin
            case (opc)
                OP_PUSH: push_req = 1'b1;
                OP_DUP: begin
                    push_val = top_r;
                    if (empty_r) begin
                        udf_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                OP_OVER: begin
                    push_val = nos_r;
                    if (depth_r < CNT_WIDTH'(2)) begin
                        udf_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty_r) begin
                        udf_set = 1'b1;
                    end else begin
                        top_nxt = nos_r;
                        pop_req = 1'b1;
                    end
                end
                OP_REPLACE2: begin
                    if (depth_r < CNT_WIDTH'(2)) begin
                        udf_set = 1'b1;
                    end else begin
                        top_nxt = op.push_data;
                        pop_req = 1'b1;
                    end
                end
                OP_SWAP: begin
                    if (depth_r < CNT_WIDTH'(2)) begin
                        udf_set = 1'b1;
                    end else begin
                        top_nxt = nos_r;
                        nos_nxt = top_r;
                    end
                end
                OP_CLEAR: begin
                    top_nxt   = '0;
                    nos_nxt   = '0;
                    depth_nxt = '0;
                end
                default: top_nxt = top_r;
            endcase

            if (push_req && full_r) begin
                ovf_set = 1'b1;
            end else if (push_req) begin
                top_nxt   = push_val;
                nos_nxt   = top_r;
                depth_nxt = depth_r + CNT_WIDTH'(1);
            end else if (pop_req) begin
                depth_nxt = depth_r - CNT_WIDTH'(1);
                // Deep pops keep NOS until the refill lands; shallow ones zero it.
                nos_nxt   = (depth_r >= CNT_WIDTH'(3)) ? nos_r : '0;
            end else begin
                depth_nxt = depth_nxt;
            end
        end else begin
            depth_nxt = depth_r;
        end
    end

    // Spill RAM control: write NOS on a deep push, read RAM top on a deep pop.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = spill_wr_addr;
        refill_go = 1'b0;
        if (push_go && (depth_r >= CNT_WIDTH'(2))) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end else if (pop_req && (depth_r >= CNT_WIDTH'(3))) begin
            ram_en    = 1'b1;
            ram_addr  = spill_rd_addr;
            refill_go = 1'b1;
        end else begin
            ram_en = 1'b0;
        end
    end

    // Architectural state and sticky error flags; a set beats clear_err.
    always_ff @(posedge general_clk) begin
        if (general_reset) begin
            top_r   <= '0;
            nos_r   <= '0;
            depth_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            top_r   <= top_nxt;
            nos_r   <= nos_nxt;
            depth_r <= depth_nxt;
            empty_r <= (depth_nxt == '0);
            full_r  <= (depth_nxt == DEPTH_C);
            ovf_r   <= ovf_set | (ovf_r & ~clear_err);
            udf_r   <= udf_set | (udf_r & ~clear_err);
        end
    end

    pampy_spill_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (SPILL_WORDS)
    ) u_spill_ram (
        .clk   (general_clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (nos_r),
        .rdata (ram_rdata)
    );

    assign op.op_ready    = ready_r;
    assign top_out        = top_r;
    assign next_out       = nos_r;
    assign depth_out      = depth_r;
    assign empty          = empty_r;
    assign full           = full_r;
    assign err_overflow   = ovf_r;
    assign err_underflow  = udf_r;

endmodule

// File: tb/tb_pampy_stack_engine.sv
// Scoreboard bench for pampy_stack_engine: a queue-based reference stack
// predicts each operation's visible result, compared once the op completes.
module tb_pampy_stack_engine;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int CW = 5;

    typedef struct packed {
        logic [DW-1:0] top;
        logic [DW-1:0] nxt;
        logic [CW-1:0] depth;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          udf;
        logic          refill;
    } exp_t;

    logic          general_clk = 1'b0;
    logic          general_reset;
    logic          clear_err;
    logic [DW-1:0] top_out, next_out;
    logic [CW-1:0] depth_out;
    logic          empty, full, err_overflow, err_underflow;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [DW-1:0] mstk[$];
    logic          m_ovf, m_udf;
    exp_t          exp_q[$];

    pampy_stack_engine_if #(.DATA_WIDTH(DW)) op_if ();

    pampy_stack_engine #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .general_clk   (general_clk),
        .general_reset (general_reset),
        .op            (op_if),
        .clear_err     (clear_err),
        .top_out       (top_out),
        .next_out      (next_out),
        .depth_out     (depth_out),
        .empty         (empty),
        .full          (full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 general_clk = ~general_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (op_if.op_ready !== 1'b1 && k < 8) begin
            @(negedge general_clk);
            k++;
        end
        if (op_if.op_ready !== 1'b1) check_eq("ready_timeout", 32'(op_if.op_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge general_clk);
        general_reset = 1'b1;
        @(negedge general_clk);
        @(negedge general_clk);
        general_reset = 1'b0;
        mstk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Reference model step; pushes the predicted outcome onto the scoreboard.
    task automatic model_step(input logic [2:0] code, input logic [DW-1:0] data, input logic clr);
        int   sz = mstk.size();
        logic so = 1'b0, su = 1'b0, rf = 1'b0;
        logic [DW-1:0] t;
        exp_t e;
        case (code)
            3'd1: if (sz == DP) so = 1'b1; else mstk.push_back(data);
            3'd2: begin
                if (sz == 0) su = 1'b1;
                else begin rf = (sz >= 3); void'(mstk.pop_back()); end
            end
            3'd3: begin
                if (sz == 0) su = 1'b1;
                else if (sz == DP) so = 1'b1;
                else mstk.push_back(mstk[sz-1]);
            end
            3'd4: begin
                if (sz < 2) su = 1'b1;
                else begin t = mstk[sz-1]; mstk[sz-1] = mstk[sz-2]; mstk[sz-2] = t; end
            end
            3'd5: begin
                if (sz < 2) su = 1'b1;
                else if (sz == DP) so = 1'b1;
                else mstk.push_back(mstk[sz-2]);
            end
            3'd6: begin
                if (sz < 2) su = 1'b1;
                else begin
                    rf = (sz >= 3);
                    void'(mstk.pop_back());
                    void'(mstk.pop_back());
                    mstk.push_back(data);
                end
            end
            3'd7: mstk.delete();
            default: ;
        endcase
        m_ovf = so | (m_ovf & ~clr);
        m_udf = su | (m_udf & ~clr);
        sz = mstk.size();
        e.top    = (sz > 0) ? mstk[sz-1] : '0;
        e.nxt    = (sz > 1) ? mstk[sz-2] : '0;
        e.depth  = CW'(sz);
        e.empty  = (sz == 0);
        e.full   = (sz == DP);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        e.refill = rf;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [2:0] code, input logic [DW-1:0] data, input logic clr);
        exp_t e;
        wait_ready();
        model_step(code, data, clr);
        op_if.op_valid  = 1'b1;
        op_if.op_code   = code;
        op_if.push_data = data;
        clear_err       = clr;
        @(posedge general_clk);
        @(negedge general_clk);
        op_if.op_valid = 1'b0;
        clear_err      = 1'b0;
        e = exp_q.pop_front();
        check_eq("ready_after_op", 32'(op_if.op_ready), 32'(!e.refill));
        if (e.refill) begin
            @(negedge general_clk);
            check_eq("refill_one_cycle", 32'(op_if.op_ready), 32'd1);
        end
        check_eq("top", 32'(top_out), 32'(e.top));
        check_eq("next", 32'(next_out), 32'(e.nxt));
        check_eq("depth", 32'(depth_out), 32'(e.depth));
        check_eq("empty", 32'(empty), 32'(e.empty));
        check_eq("full", 32'(full), 32'(e.full));
        check_eq("err_ovf", 32'(err_overflow), 32'(e.ovf));
        check_eq("err_udf", 32'(err_underflow), 32'(e.udf));
    endtask

    initial begin
        general_reset   = 1'b1;
        clear_err       = 1'b0;
        op_if.op_valid  = 1'b0;
        op_if.op_code   = 3'd0;
        op_if.push_data = '0;
        do_reset();

        check_eq("rst_ready", 32'(op_if.op_ready), 32'd1);
        check_eq("rst_depth", 32'(depth_out), 32'd0);
        check_eq("rst_top", 32'(top_out), 32'd0);
        check_eq("rst_next", 32'(next_out), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_errs", 32'({err_overflow, err_underflow}), 32'd0);

        // Basic push/pop with one refill
        apply(3'd1, 8'h11, 1'b0);
        apply(3'd1, 8'h22, 1'b0);
        apply(3'd1, 8'h33, 1'b0);
        apply(3'd2, 8'h00, 1'b0);

        // Fill to the brim, then overflow attempts
        apply(3'd7, 8'h00, 1'b0);
        for (int i = 0; i < DP; i++) apply(3'd1, 8'(8'h40 + i), 1'b0);
        apply(3'd1, 8'hAA, 1'b0);
        apply(3'd0, 8'h00, 1'b1);
        apply(3'd3, 8'h00, 1'b0);
        apply(3'd5, 8'h00, 1'b1);
        for (int i = 0; i < DP; i++) apply(3'd2, 8'h00, 1'b0);

        // Underflow cases, including set-beats-clear
        apply(3'd0, 8'h00, 1'b1);
        apply(3'd1, 8'h5C, 1'b0);
        apply(3'd4, 8'h00, 1'b1);
        apply(3'd6, 8'h77, 1'b0);
        apply(3'd5, 8'h00, 1'b0);
        apply(3'd2, 8'h00, 1'b0);
        apply(3'd2, 8'h00, 1'b0);
        apply(3'd3, 8'h00, 1'b0);

        // REPLACE2 then SWAP
        apply(3'd0, 8'h00, 1'b1);
        apply(3'd1, 8'h05, 1'b0);
        apply(3'd1, 8'h07, 1'b0);
        apply(3'd1, 8'h09, 1'b0);
        apply(3'd6, 8'h10, 1'b0);
        apply(3'd4, 8'h00, 1'b0);

        // Random mix, biased toward pushes
        for (int i = 0; i < 300; i++) begin
            int r = int'($urandom_range(0, 11));
            logic [2:0] c = (r > 7) ? 3'd1 : 3'(r);
            if (c == 3'd7 && $urandom_range(0, 3) != 0) c = 3'd2;
            apply(c, 8'($urandom), ($urandom_range(0, 9) == 0));
        end

        // Reset while a refill is in flight
        apply(3'd7, 8'h00, 1'b0);
        apply(3'd1, 8'h0A, 1'b0);
        apply(3'd1, 8'h0B, 1'b0);
        apply(3'd1, 8'h0C, 1'b0);
        @(negedge general_clk);
        op_if.op_valid = 1'b1;
        op_if.op_code  = 3'd2;
        @(posedge general_clk);
        @(negedge general_clk);
        op_if.op_valid = 1'b0;
        check_eq("in_refill", 32'(op_if.op_ready), 32'd0);
        general_reset = 1'b1;
        @(negedge general_clk);
        general_reset = 1'b0;
        mstk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_eq("rr_ready", 32'(op_if.op_ready), 32'd1);
        check_eq("rr_depth", 32'(depth_out), 32'd0);
        check_eq("rr_empty", 32'(empty), 32'd1);
        @(negedge general_clk);
        check_eq("rr_idle_hold", 32'(op_if.op_ready), 32'd1);
        apply(3'd1, 8'h01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pampy_stack_engine.md
PAMPY_STACK_ENGINE -- requirements
Module: pampy_stack_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one stack entry.
REQ-002 Parameter DEPTH, default 16, total entries; power of two, 4 to 256.
REQ-003 Derived constant CNT_WIDTH = clog2(DEPTH)+1, the width of the occupancy count.
REQ-004 general_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 general_reset  in  1  synchronous, active-high reset.
REQ-006 op_valid  in  1  operation request.
REQ-007 op_ready  out  1  engine accepts an operation this cycle.
REQ-008 op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 REPLACE2 (pop two, push push_data), 7 CLEAR.
REQ-009 push_data  in  DATA_WIDTH  data for PUSH and REPLACE2.
REQ-010 top_out  out  DATA_WIDTH  top of stack (TOS) register.
REQ-011 next_out  out  DATA_WIDTH  next-on-stack (NOS) register.
REQ-012 depth_out  out  CNT_WIDTH  current occupancy, 0 to DEPTH.
REQ-013 empty, full  out  1 each  depth_out==0 / depth_out==DEPTH.
REQ-014 err_overflow, err_underflow  out  1 each  sticky error flags.
REQ-015 clear_err  in  1  clears both sticky flags.

Function
REQ-016 An operation is accepted when op_valid and op_ready are both high; results are visible on the outputs the cycle after acceptance.
REQ-017 TOS and NOS are held in registers; entries 3..DEPTH live in a single-port, synchronous-read spill RAM of DEPTH-2 words.
REQ-018 FSM states: IDLE (op_ready=1) and REFILL (op_ready=0); the FSM moves IDLE->REFILL on an accepted POP or REPLACE2 with depth_out>=3 and returns REFILL->IDLE after exactly one cycle.
REQ-019 PUSH: NOS spills to RAM if depth_out>=2, TOS->NOS, push_data->TOS, depth+1.
REQ-020 POP: NOS->TOS, depth-1; if depth_out was >=3, the RAM top is read and loaded into NOS at the end of REFILL.
REQ-021 DUP: same as PUSH with TOS as the data. OVER: same as PUSH with NOS as the data.
REQ-022 SWAP exchanges TOS and NOS; depth is unchanged, no RAM access, and there is no REFILL.
REQ-023 REPLACE2: push_data->TOS, depth-1; NOS is refilled as for POP.
REQ-024 CLEAR sets depth to 0 and leaves RAM contents unchanged; it is never an error.
REQ-025 Overflow: PUSH, DUP or OVER with full=1 leaves all state unchanged and sets err_overflow.
REQ-026 Underflow: POP or DUP with depth 0, or SWAP, OVER or REPLACE2 with depth<2, leaves all state unchanged and sets err_underflow.
REQ-027 top_out is 0 when depth is 0; next_out is 0 when depth<2.
REQ-028 clear_err and an error event in the same cycle: the set wins.
REQ-029 NOP and non-accepted cycles change no state.
REQ-030 Ops presented while in REFILL are held off by op_ready=0; the requester keeps them stable until accepted.

Reset
REQ-031 general_reset forces IDLE, depth_out=0, top_out=0, next_out=0, empty=1, full=0, and clears both error flags.
REQ-032 Reset asserted during REFILL abandons the refill; the first cycle after reset is IDLE with op_ready=1.
REQ-033 Spill RAM contents are not reset.

Structure
REQ-034 Op-code constants, the FSM state encoding and the CNT_WIDTH calculation belong in the shared pampy package.
REQ-035 The spill RAM is one sub-module, pampy_spill_ram, parametrised by DATA_WIDTH and depth.
REQ-036 The engine is a drop-in replacement for the current stack path inside BLOCK_STACK_TOS.

Verification
REQ-037 Reset, then PUSH 0x11, 0x22, 0x33 -> top_out=0x33, next_out=0x22, depth_out=3, op_ready stays 1.
REQ-038 From the state in REQ-037, POP -> op_ready=0 for one cycle, then top_out=0x22, next_out=0x11, depth_out=2.
REQ-039 DEPTH=16: 16 PUSHes then PUSH 0xAA -> depth_out=16, full=1, top_out unchanged, err_overflow=1; clear_err -> flag=0.
REQ-040 Depth 1, SWAP -> err_underflow=1, state unchanged; the same cycle with clear_err=1 -> flag still 1.
REQ-041 Stack 5,7,9 (TOS 9): REPLACE2 0x10 -> top_out=0x10, next_out=5, depth_out=2; SWAP -> top_out=5, next_out=0x10.
REQ-042 Reset asserted during REFILL -> the next cycle is IDLE, depth_out=0, empty=1; PUSH 0x01 -> top_out=0x01, depth_out=1.
